// File: rtl/gcd_scheduler_pkg.sv
// Shared definitions for the GCD request scheduler: FSM state encoding and
// default sizing values used by gcd_scheduler and rr_pick.
package gcd_scheduler_pkg;

    localparam int DEF_N   = 4;     // requesters sharing the engine
    localparam int DEF_W   = 16;    // operand / result width
    localparam int DEF_TMO = 1024;  // engine timeout in cycles

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/gcd_scheduler_rr_pick.sv
// Round-robin selector: grants the first asserted request at or after ptr,
// wrapping modulo N.
//   req   in  N   request vector
//   ptr   in  IW  highest-priority index (must be < N)
//   grant out N   one-hot grant (all zero when no request)
//   idx   out IW  index of the granted requester
//   any   out 1   at least one request asserted
module rr_pick
    import gcd_scheduler_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                any = 1'b1;
                idx = IW'((int'(ptr) + k) % N);
                grant[(int'(ptr) + k) % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_scheduler.sv
// Shares one external GCD engine between N requesters. Requests are granted
// round-robin, operands with a zero bypass the engine, and a stuck engine is
// abandoned after TMO cycles with an error response.
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_a/req_b    per-requester request and packed operands
//   req_ready                one-hot accept pulse
//   eng_start/eng_a/eng_b    engine launch pulse and held operands
//   eng_done/eng_result      engine completion and result
//   rsp_valid/rsp_data/rsp_err  one-hot response pulse, result, timeout flag
//   busy                     scheduler not idle
//
// state  | meaning
// IDLE   | waiting for a request; grants and latches operands
// LAUNCH | issues the engine start, clears the timer
// WAIT   | waiting for eng_done or timeout
// RESP   | returns result to the owner, advances the round-robin pointer
//
// Every output is a register loaded from the current state's decision, so
// outputs appear one cycle after the state that produces them.
module gcd_scheduler
    import gcd_scheduler_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int W   = DEF_W,
    parameter int TMO = DEF_TMO
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic [N-1:0]   req_ready,
    output logic           eng_start,
    output logic [W-1:0]   eng_a,
    output logic [W-1:0]   eng_b,
    input  logic           eng_done,
    input  logic [W-1:0]   eng_result,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_err,
    output logic           busy
);

    localparam int IW = $clog2(N);
    localparam int TW = $clog2(TMO) + 1;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   id_q, id_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic            err_q, err_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [N-1:0]    ready_q, ready_d;
    logic            start_q, start_d;
    logic [N-1:0]    rspv_q, rspv_d;
    logic [W-1:0]    rspd_q, rspd_d;
    logic            rspe_q, rspe_d;
    logic            busy_q, busy_d;

    logic [N-1:0]    grant;
    logic [IW-1:0]   gidx;
    logic            gany;

    rr_pick #(.N(N), .IW(IW)) u_rr_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            timer_q <= '0;
            ready_q <= '0;
            start_q <= 1'b0;
            rspv_q  <= '0;
            rspd_q  <= '0;
            rspe_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
            timer_q <= timer_d;
            ready_q <= ready_d;
            start_q <= start_d;
            rspv_q  <= rspv_d;
            rspd_q  <= rspd_d;
            rspe_q  <= rspe_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        timer_d = timer_q;
        ready_d = '0;
        start_d = 1'b0;
        rspv_d  = '0;
        rspd_d  = '0;
        rspe_d  = 1'b0;
        busy_d  = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (gany) begin
                    ready_d = grant;
                    id_d    = gidx;
                    a_d     = req_a[int'(gidx)*W +: W];
                    b_d     = req_b[int'(gidx)*W +: W];
                    if (a_d == '0 || b_d == '0) begin
                        // gcd(x,0) = x and gcd(0,0) = 0, so OR gives the answer
                        res_d   = a_d | b_d;
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else begin
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                start_d = 1'b1;
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // completion wins over a timeout landing in the same cycle
                if (eng_done) begin
                    res_d   = eng_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timer_q == TW'(TMO - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                rspv_d[id_q] = 1'b1;
                rspd_d       = res_q;
                rspe_d       = err_q;
                ptr_d        = (id_q == IW'(N - 1)) ? '0 : id_q + IW'(1);
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = ready_q;
    assign eng_start = start_q;
    assign eng_a     = a_q;
    assign eng_b     = b_q;
    assign rsp_valid = rspv_q;
    assign rsp_data  = rspd_q;
    assign rsp_err   = rspe_q;
    assign busy      = busy_q;

endmodule
